// File: rtl/register_file_bank.sv
// Multi-port register file: two combinational read ports, ALU and load write ports,
// and a per-register pending-load scoreboard with a registered write-after-write hazard pulse.
module register_file_bank #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Clear,
  input  logic [ADDR_W-1:0] ReadA,
  input  logic [ADDR_W-1:0] ReadB,
  output logic [DATA_W-1:0] DataA,
  output logic [DATA_W-1:0] DataB,
  output logic              BusyA,
  output logic              BusyB,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              LoadIssue,
  input  logic [ADDR_W-1:0] LoadIssueReg,
  input  logic              LoadWrite,
  input  logic [ADDR_W-1:0] LoadReg,
  input  logic [DATA_W-1:0] LoadData,
  output logic              Hazard
);

  logic [DATA_W-1:0]   rf [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic                hazard_p1;

  logic ld_en;
  logic alu_en;
  logic iss_en;
  logic alu_req;
  logic pend_wr;
  logic hazard_d;

  // An address names real storage only if it is in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    addr_ok = (32'(a) < 32'(NUM_REGS)) && !(ZERO_REG && (a == '0));
  endfunction

  // Returns {busy, data} for one read port; busy always reflects pre-edge state.
  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    logic              b;
    d = '0;
    b = 1'b0;
    if (addr_ok(a)) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (a == ADDR_W'(i)) begin
          d = rf[i];
          b = pending[i];
        end
      end
    end
    if (BYPASS && Reset && !Clear) begin
      if (ld_en && (LoadReg == a)) begin
        d = LoadData;
      end else if (alu_en && (WriteReg == a)) begin
        d = WriteData;
      end
    end
    read_port = {b, d};
  endfunction

  // ---- write-port decode (pre-edge) ----
  assign ld_en   = LoadWrite && addr_ok(LoadReg);
  assign alu_req = RegWrite && addr_ok(WriteReg);
  // A load completion to the same register wins; the ALU write is discarded.
  assign alu_en  = alu_req && !(ld_en && (LoadReg == WriteReg));
  assign iss_en  = LoadIssue && addr_ok(LoadIssueReg);

  always_comb begin
    pend_wr = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (WriteReg == ADDR_W'(i)) begin
        pend_wr = pending[i];
      end
    end
  end

  // Hazard looks at the ALU request, not alu_en: a same-cycle load completion does not mask it.
  assign hazard_d = alu_req && pend_wr;

  // ---- state update at posedge (p1) ----
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (Clear) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ld_en && (LoadReg == ADDR_W'(i))) begin
          rf[i] <= LoadData;
        end else if (alu_en && (WriteReg == ADDR_W'(i))) begin
          rf[i] <= WriteData;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pending   <= '0;
      hazard_p1 <= 1'b0;
    end else if (Clear) begin
      pending   <= '0;
      hazard_p1 <= 1'b0;
    end else begin
      hazard_p1 <= hazard_d;
      // A new issue to the register being completed keeps it outstanding.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (iss_en && (LoadIssueReg == ADDR_W'(i))) begin
          pending[i] <= 1'b1;
        end else if (ld_en && (LoadReg == ADDR_W'(i))) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // ---- read ports (combinational) ----
  always_comb begin
    logic [DATA_W:0] pa;
    logic [DATA_W:0] pb;
    pa    = read_port(ReadA);
    pb    = read_port(ReadB);
    DataA = pa[DATA_W-1:0];
    BusyA = pa[DATA_W];
    DataB = pb[DATA_W-1:0];
    BusyB = pb[DATA_W];
  end

  assign Hazard = hazard_p1;

endmodule

// File: tb/tb_register_file_bank.sv
// Directed bench for register_file_bank: default instance plus a 3-register,
// zero-register, no-bypass instance driven by the same stimulus.
module tb_register_file_bank;

  logic       Clock;
  logic       Reset;
  logic       Clear;
  logic [1:0] ReadA, ReadB;
  logic       RegWrite;
  logic [1:0] WriteReg;
  logic [7:0] WriteData;
  logic       LoadIssue;
  logic [1:0] LoadIssueReg;
  logic       LoadWrite;
  logic [1:0] LoadReg;
  logic [7:0] LoadData;

  logic [7:0] DataA, DataB, zDataA, zDataB;
  logic       BusyA, BusyB, zBusyA, zBusyB;
  logic       Hazard, zHazard;

  int n_assert = 0;
  int n_fail   = 0;

  register_file_bank u_dut (
    .Clock(Clock), .Reset(Reset), .Clear(Clear),
    .ReadA(ReadA), .ReadB(ReadB), .DataA(DataA), .DataB(DataB),
    .BusyA(BusyA), .BusyB(BusyB),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .LoadIssue(LoadIssue), .LoadIssueReg(LoadIssueReg),
    .LoadWrite(LoadWrite), .LoadReg(LoadReg), .LoadData(LoadData),
    .Hazard(Hazard)
  );

  register_file_bank #(.NUM_REGS(3), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dz (
    .Clock(Clock), .Reset(Reset), .Clear(Clear),
    .ReadA(ReadA), .ReadB(ReadB), .DataA(zDataA), .DataB(zDataB),
    .BusyA(zBusyA), .BusyB(zBusyB),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .LoadIssue(LoadIssue), .LoadIssueReg(LoadIssueReg),
    .LoadWrite(LoadWrite), .LoadReg(LoadReg), .LoadData(LoadData),
    .Hazard(zHazard)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    Clear = 1'b0; RegWrite = 1'b0; LoadIssue = 1'b0; LoadWrite = 1'b0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b1; idle();
    ReadA = 2'd0; ReadB = 2'd0;
    WriteReg = 2'd0; WriteData = 8'h00;
    LoadIssueReg = 2'd0; LoadReg = 2'd0; LoadData = 8'h00;
    #1 Reset = 1'b0;
    #2;
    chk("rst_DataA", DataA, 0);
    chk("rst_BusyA", BusyA, 0);
    chk("rst_Hazard", Hazard, 0);
    chk("rst_zDataB", zDataB, 0);
    repeat (2) @(posedge Clock);
    @(negedge Clock) Reset = 1'b1;
    tick();

    // ALU write with bypass
    ReadA = 2'd2; RegWrite = 1'b1; WriteReg = 2'd2; WriteData = 8'h5A;
    #1;
    chk("byp_DataA", DataA, 8'h5A);
    chk("nobyp_zDataA", zDataA, 8'h00);
    tick(); idle(); #1;
    chk("wr_DataA", DataA, 8'h5A);
    chk("wr_zDataA", zDataA, 8'h5A);
    chk("wr_Hazard", Hazard, 0);

    // ALU and load to the same register: load wins
    ReadA = 2'd1; ReadB = 2'd2;
    RegWrite = 1'b1; WriteReg = 2'd1; WriteData = 8'h11;
    LoadWrite = 1'b1; LoadReg = 2'd1; LoadData = 8'h22;
    #1;
    chk("same_byp_DataA", DataA, 8'h22);
    chk("same_nobyp_zDataA", zDataA, 8'h00);
    tick(); idle(); #1;
    chk("same_DataA", DataA, 8'h22);
    chk("same_zDataA", zDataA, 8'h22);
    chk("same_DataB", DataB, 8'h5A);

    // Split writes: both land; reg3 is out of range on the 3-register instance
    ReadA = 2'd1; ReadB = 2'd3;
    RegWrite = 1'b1; WriteReg = 2'd1; WriteData = 8'h33;
    LoadWrite = 1'b1; LoadReg = 2'd3; LoadData = 8'h44;
    #1;
    chk("split_byp_DataA", DataA, 8'h33);
    chk("split_byp_DataB", DataB, 8'h44);
    chk("split_nobyp_zDataA", zDataA, 8'h22);
    tick(); idle(); #1;
    chk("split_DataA", DataA, 8'h33);
    chk("split_DataB", DataB, 8'h44);
    chk("split_zDataA", zDataA, 8'h33);
    chk("oor_zDataB", zDataB, 8'h00);

    // Load issue, hazard, completion
    LoadIssue = 1'b1; LoadIssueReg = 2'd3;
    #1;
    chk("iss_pre_BusyB", BusyB, 0);
    tick(); idle(); #1;
    chk("iss_BusyB", BusyB, 1);
    chk("oor_zBusyB", zBusyB, 0);
    RegWrite = 1'b1; WriteReg = 2'd3; WriteData = 8'h55;
    #1;
    chk("haz_pre", Hazard, 0);
    tick(); idle(); #1;
    chk("haz_pulse", Hazard, 1);
    chk("haz_oor_z", zHazard, 0);
    chk("haz_DataB", DataB, 8'h55);
    chk("haz_BusyB", BusyB, 1);
    tick(); #1;
    chk("haz_drop", Hazard, 0);
    LoadWrite = 1'b1; LoadReg = 2'd3; LoadData = 8'h7F;
    #1;
    chk("cmp_pre_BusyB", BusyB, 1);
    chk("cmp_byp_DataB", DataB, 8'h7F);
    tick(); idle(); #1;
    chk("cmp_BusyB", BusyB, 0);
    chk("cmp_DataB", DataB, 8'h7F);

    // Hazard still raised when a load completes the same register that cycle
    ReadA = 2'd1; LoadIssue = 1'b1; LoadIssueReg = 2'd1;
    tick(); idle(); #1;
    chk("h2_BusyA", BusyA, 1);
    chk("h2_zBusyA", zBusyA, 1);
    RegWrite = 1'b1; WriteReg = 2'd1; WriteData = 8'h01;
    LoadWrite = 1'b1; LoadReg = 2'd1; LoadData = 8'h02;
    #1;
    chk("h2_byp_DataA", DataA, 8'h02);
    chk("h2_nobyp_zDataA", zDataA, 8'h33);
    tick(); idle(); #1;
    chk("h2_Hazard", Hazard, 1);
    chk("h2_zHazard", zHazard, 1);
    chk("h2_DataA", DataA, 8'h02);
    chk("h2_zDataA", zDataA, 8'h02);
    chk("h2_BusyA_clr", BusyA, 0);

    // Issue and completion to the same register: stays pending
    ReadA = 2'd2;
    LoadIssue = 1'b1; LoadIssueReg = 2'd2;
    LoadWrite = 1'b1; LoadReg = 2'd2; LoadData = 8'h66;
    tick(); idle(); #1;
    chk("ic_BusyA", BusyA, 1);
    chk("ic_DataA", DataA, 8'h66);
    chk("ic_zBusyA", zBusyA, 1);
    chk("ic_zDataA", zDataA, 8'h66);

    // Register 0: ordinary on the default instance, hardwired zero on the other
    ReadA = 2'd0;
    RegWrite = 1'b1; WriteReg = 2'd0; WriteData = 8'hFF;
    LoadIssue = 1'b1; LoadIssueReg = 2'd0;
    #1;
    chk("r0_byp_DataA", DataA, 8'hFF);
    chk("r0_zDataA_pre", zDataA, 8'h00);
    tick(); idle(); #1;
    chk("r0_DataA", DataA, 8'hFF);
    chk("r0_BusyA", BusyA, 1);
    chk("r0_zDataA", zDataA, 8'h00);
    chk("r0_zBusyA", zBusyA, 0);
    RegWrite = 1'b1; WriteReg = 2'd0; WriteData = 8'hEE;
    tick(); idle(); #1;
    chk("r0_Hazard", Hazard, 1);
    chk("r0_zHazard", zHazard, 0);
    chk("r0_DataA2", DataA, 8'hEE);

    // Clear overrides every write and issue and disables bypass
    ReadA = 2'd1; ReadB = 2'd2; Clear = 1'b1;
    RegWrite = 1'b1; WriteReg = 2'd1; WriteData = 8'hAA;
    LoadWrite = 1'b1; LoadReg = 2'd2; LoadData = 8'hBB;
    LoadIssue = 1'b1; LoadIssueReg = 2'd3;
    #1;
    chk("clr_pre_DataA", DataA, 8'h02);
    chk("clr_pre_DataB", DataB, 8'h66);
    chk("clr_pre_BusyB", BusyB, 1);
    tick(); idle(); #1;
    chk("clr_DataA", DataA, 8'h00);
    chk("clr_DataB", DataB, 8'h00);
    chk("clr_BusyB", BusyB, 0);
    chk("clr_Hazard", Hazard, 0);
    chk("clr_zDataA", zDataA, 8'h00);
    ReadA = 2'd0; ReadB = 2'd3;
    #1;
    chk("clr_BusyA0", BusyA, 0);
    chk("clr_BusyB3", BusyB, 0);
    chk("clr_DataB3", DataB, 8'h00);

    // Asynchronous reset mid-run
    ReadA = 2'd1;
    RegWrite = 1'b1; WriteReg = 2'd1; WriteData = 8'h12;
    LoadIssue = 1'b1; LoadIssueReg = 2'd1;
    tick(); idle();
    RegWrite = 1'b1; WriteReg = 2'd1; WriteData = 8'h13;
    tick(); idle(); #1;
    chk("ar_pre_Hazard", Hazard, 1);
    chk("ar_pre_DataA", DataA, 8'h13);
    chk("ar_pre_BusyA", BusyA, 1);
    ReadB = 2'd2; RegWrite = 1'b1; WriteReg = 2'd2; WriteData = 8'h77;
    #1;
    chk("ar_pre_byp_DataB", DataB, 8'h77);
    Reset = 1'b0;
    #1;
    chk("ar_DataA", DataA, 8'h00);
    chk("ar_DataB", DataB, 8'h00);
    chk("ar_BusyA", BusyA, 0);
    chk("ar_Hazard", Hazard, 0);
    chk("ar_zDataA", zDataA, 8'h00);
    idle();
    @(posedge Clock);
    @(negedge Clock) Reset = 1'b1;
    tick(); #1;
    chk("ar_post_DataA", DataA, 8'h00);
    chk("ar_post_DataB", DataB, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
